// File: rtl/axi_latency_injector.sv
// ============================================================================
// Module   : axi_latency_injector
// Purpose  : AXI delay line; every channel is a timestamped FIFO that releases
//            a beat once it has aged a runtime-programmable number of cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_latency_injector_pkg;

  typedef logic [15:0] lat_aw_chan_t;
  typedef logic [15:0] lat_w_chan_t;
  typedef logic [7:0]  lat_b_chan_t;
  typedef logic [15:0] lat_ar_chan_t;
  typedef logic [15:0] lat_r_chan_t;

  typedef struct packed {
    lat_aw_chan_t aw;
    logic         aw_valid;
    lat_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    lat_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } lat_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    lat_b_chan_t  b;
    logic         b_valid;
    lat_r_chan_t  r;
    logic         r_valid;
  } lat_resp_t;

endpackage

module axi_latency_injector_fifo #(
  parameter type         data_t      = logic,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DELAY_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DELAY_WIDTH-1:0] i_delay,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  data_t                  i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output data_t                  o_data,
  output logic                   o_empty
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0]     c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0]     c_cnt_full = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0]     c_cnt_one  = c_cnt_w'(1);
  localparam logic [DELAY_WIDTH-1:0] c_age_max  = '1;
  localparam logic [DELAY_WIDTH-1:0] c_age_one  = DELAY_WIDTH'(1);

  data_t                  r_data [DEPTH];
  logic [DELAY_WIDTH-1:0] r_age  [DEPTH];
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_cnt_w-1:0]     r_count;
  logic                   r_commit;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_valid;
  logic                   w_push;
  logic                   w_pop;
  logic [DELAY_WIDTH-1:0] w_head_age;

  function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Once committed the head stays valid regardless of later delay changes.
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == c_cnt_full);
    w_head_age = r_age[r_rd_ptr];
    w_valid    = !w_empty && ((w_head_age >= i_delay) || r_commit);
    w_push     = i_valid && !w_full;
    w_pop      = w_valid && i_ready;
  end

  assign o_ready = !w_full;
  assign o_valid = w_valid;
  assign o_data  = r_data[r_rd_ptr];
  assign o_empty = w_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= i_data;
    end
  end

  // Ages saturate so a long downstream stall can never wrap an entry back below the delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wr_ptr == c_ptr_w'(i))) begin
          r_age[i] <= '0;
        end else if (r_age[i] != c_age_max) begin
          r_age[i] <= r_age[i] + c_age_one;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_commit <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_commit <= 1'b0;
      end else if (w_valid && !i_ready) begin
        r_commit <= 1'b1;
      end
    end
  end

endmodule

module axi_latency_injector #(
  parameter type         aw_chan_t   = axi_latency_injector_pkg::lat_aw_chan_t,
  parameter type         w_chan_t    = axi_latency_injector_pkg::lat_w_chan_t,
  parameter type         b_chan_t    = axi_latency_injector_pkg::lat_b_chan_t,
  parameter type         ar_chan_t   = axi_latency_injector_pkg::lat_ar_chan_t,
  parameter type         r_chan_t    = axi_latency_injector_pkg::lat_r_chan_t,
  parameter type         req_t       = axi_latency_injector_pkg::lat_req_t,
  parameter type         resp_t      = axi_latency_injector_pkg::lat_resp_t,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DELAY_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DELAY_WIDTH-1:0] cfg_req_delay_i,
  input  logic [DELAY_WIDTH-1:0] cfg_resp_delay_i,
  input  req_t                   slv_req_i,
  output resp_t                  slv_resp_o,
  output req_t                   mst_req_o,
  input  resp_t                  mst_resp_i,
  output logic                   busy_o
);

  logic     w_aw_in_ready, w_aw_out_valid, w_aw_empty;
  logic     w_w_in_ready,  w_w_out_valid,  w_w_empty;
  logic     w_ar_in_ready, w_ar_out_valid, w_ar_empty;
  logic     w_b_in_ready,  w_b_out_valid,  w_b_empty;
  logic     w_r_in_ready,  w_r_out_valid,  w_r_empty;
  aw_chan_t w_aw_out_data;
  w_chan_t  w_w_out_data;
  ar_chan_t w_ar_out_data;
  b_chan_t  w_b_out_data;
  r_chan_t  w_r_out_data;

  // Request channels flow slave -> master.
  axi_latency_injector_fifo #(
    .data_t(aw_chan_t), .DEPTH(DEPTH), .DELAY_WIDTH(DELAY_WIDTH)
  ) u_aw_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_delay(cfg_req_delay_i),
    .i_valid(slv_req_i.aw_valid), .o_ready(w_aw_in_ready), .i_data(slv_req_i.aw),
    .o_valid(w_aw_out_valid), .i_ready(mst_resp_i.aw_ready), .o_data(w_aw_out_data),
    .o_empty(w_aw_empty)
  );

  axi_latency_injector_fifo #(
    .data_t(w_chan_t), .DEPTH(DEPTH), .DELAY_WIDTH(DELAY_WIDTH)
  ) u_w_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_delay(cfg_req_delay_i),
    .i_valid(slv_req_i.w_valid), .o_ready(w_w_in_ready), .i_data(slv_req_i.w),
    .o_valid(w_w_out_valid), .i_ready(mst_resp_i.w_ready), .o_data(w_w_out_data),
    .o_empty(w_w_empty)
  );

  axi_latency_injector_fifo #(
    .data_t(ar_chan_t), .DEPTH(DEPTH), .DELAY_WIDTH(DELAY_WIDTH)
  ) u_ar_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_delay(cfg_req_delay_i),
    .i_valid(slv_req_i.ar_valid), .o_ready(w_ar_in_ready), .i_data(slv_req_i.ar),
    .o_valid(w_ar_out_valid), .i_ready(mst_resp_i.ar_ready), .o_data(w_ar_out_data),
    .o_empty(w_ar_empty)
  );

  // Response channels flow master -> slave.
  axi_latency_injector_fifo #(
    .data_t(b_chan_t), .DEPTH(DEPTH), .DELAY_WIDTH(DELAY_WIDTH)
  ) u_b_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_delay(cfg_resp_delay_i),
    .i_valid(mst_resp_i.b_valid), .o_ready(w_b_in_ready), .i_data(mst_resp_i.b),
    .o_valid(w_b_out_valid), .i_ready(slv_req_i.b_ready), .o_data(w_b_out_data),
    .o_empty(w_b_empty)
  );

  axi_latency_injector_fifo #(
    .data_t(r_chan_t), .DEPTH(DEPTH), .DELAY_WIDTH(DELAY_WIDTH)
  ) u_r_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_delay(cfg_resp_delay_i),
    .i_valid(mst_resp_i.r_valid), .o_ready(w_r_in_ready), .i_data(mst_resp_i.r),
    .o_valid(w_r_out_valid), .i_ready(slv_req_i.r_ready), .o_data(w_r_out_data),
    .o_empty(w_r_empty)
  );

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = w_aw_out_data;
    mst_req_o.aw_valid = w_aw_out_valid;
    mst_req_o.w        = w_w_out_data;
    mst_req_o.w_valid  = w_w_out_valid;
    mst_req_o.ar       = w_ar_out_data;
    mst_req_o.ar_valid = w_ar_out_valid;
    mst_req_o.b_ready  = w_b_in_ready;
    mst_req_o.r_ready  = w_r_in_ready;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = w_aw_in_ready;
    slv_resp_o.w_ready  = w_w_in_ready;
    slv_resp_o.ar_ready = w_ar_in_ready;
    slv_resp_o.b        = w_b_out_data;
    slv_resp_o.b_valid  = w_b_out_valid;
    slv_resp_o.r        = w_r_out_data;
    slv_resp_o.r_valid  = w_r_out_valid;
  end

  assign busy_o = !(w_aw_empty && w_w_empty && w_ar_empty && w_b_empty && w_r_empty);

endmodule

`default_nettype wire

// File: tb/tb_axi_latency_injector.sv
// ============================================================================
// Module   : tb_axi_latency_injector
// Purpose  : directed scoreboard bench for axi_latency_injector
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_latency_injector;
  import axi_latency_injector_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] cfg_req, cfg_resp;
  lat_req_t   slv_req, mst_req;
  lat_resp_t  slv_resp, mst_resp;
  logic       busy;

  logic [3:0] s_cfg_req, s_cfg_resp;
  lat_req_t   s_slv_req, s_mst_req;
  lat_resp_t  s_slv_resp, s_mst_resp;
  logic       s_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] aw_q[$], w_q[$], ar_q[$], r_q[$], s_aw_q[$];
  logic [7:0]  b_q[$];

  axi_latency_injector dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_delay_i(cfg_req), .cfg_resp_delay_i(cfg_resp),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .busy_o(busy)
  );

  axi_latency_injector #(.DELAY_WIDTH(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_delay_i(s_cfg_req), .cfg_resp_delay_i(s_cfg_resp),
    .slv_req_i(s_slv_req), .slv_resp_o(s_slv_resp),
    .mst_req_o(s_mst_req), .mst_resp_i(s_mst_resp),
    .busy_o(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Output-side scoreboard: every handshake that will complete at the next edge pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 32'(aw_q.size()), 32'd1);
        else chk("aw_payload", 32'(mst_req.aw), 32'(aw_q.pop_front()));
      end
      if (mst_req.w_valid && mst_resp.w_ready) begin
        if (w_q.size() == 0) chk("w_unexpected", 32'(w_q.size()), 32'd1);
        else chk("w_payload", 32'(mst_req.w), 32'(w_q.pop_front()));
      end
      if (mst_req.ar_valid && mst_resp.ar_ready) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 32'(ar_q.size()), 32'd1);
        else chk("ar_payload", 32'(mst_req.ar), 32'(ar_q.pop_front()));
      end
      if (slv_resp.b_valid && slv_req.b_ready) begin
        if (b_q.size() == 0) chk("b_unexpected", 32'(b_q.size()), 32'd1);
        else chk("b_payload", 32'(slv_resp.b), 32'(b_q.pop_front()));
      end
      if (slv_resp.r_valid && slv_req.r_ready) begin
        if (r_q.size() == 0) chk("r_unexpected", 32'(r_q.size()), 32'd1);
        else chk("r_payload", 32'(slv_resp.r), 32'(r_q.pop_front()));
      end
      if (s_mst_req.aw_valid && s_mst_resp.aw_ready) begin
        if (s_aw_q.size() == 0) chk("sat_aw_unexpected", 32'(s_aw_q.size()), 32'd1);
        else chk("sat_aw_payload", 32'(s_mst_req.aw), 32'(s_aw_q.pop_front()));
      end
    end
  end

  initial begin
    int early;
    int stale;
    rst_n      = 1'b0;
    cfg_req    = '0;
    cfg_resp   = '0;
    slv_req    = '0;
    mst_resp   = '0;
    s_cfg_req  = '0;
    s_cfg_resp = '0;
    s_slv_req  = '0;
    s_mst_resp = '0;
    #1;
    chk("rst_valids", 32'({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                           slv_resp.b_valid, slv_resp.r_valid}), 32'h0);
    chk("rst_readies", 32'({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                            mst_req.b_ready, mst_req.r_ready}), 32'h1f);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // AW single beat, delay 3: valid in the fourth cycle after acceptance.
    cfg_req = 8'd3;
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid = 1'b1;
    slv_req.aw = 16'hA5C3;
    settle();
    chk("t1_aw_ready", 32'(slv_resp.aw_ready), 32'd1);
    aw_q.push_back(16'hA5C3);
    step();
    slv_req.aw_valid = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("t1_aw_early", 32'(mst_req.aw_valid), 32'd0);
      chk("t1_aw_ready_hold", 32'(slv_resp.aw_ready), 32'd1);
      step();
    end
    chk("t1_aw_valid", 32'(mst_req.aw_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_aw_done", 32'(mst_req.aw_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // W burst of 16 with zero delay: one beat per cycle, no bubbles.
    cfg_req = 8'd0;
    mst_resp.w_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        slv_req.w_valid = 1'b1;
        slv_req.w = 16'(16'h1000 + k);
      end else begin
        slv_req.w_valid = 1'b0;
      end
      settle();
      if (k < 16) begin
        chk("t2_w_ready", 32'(slv_resp.w_ready), 32'd1);
        w_q.push_back(16'(16'h1000 + k));
      end
      chk("t2_w_valid", 32'(mst_req.w_valid), 32'(k >= 1));
      step();
    end
    chk("t2_w_idle", 32'(mst_req.w_valid), 32'd0);

    // R fill to full with delay 2, then drain at full rate.
    cfg_resp = 8'd2;
    slv_req.r_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mst_resp.r_valid = 1'b1;
      mst_resp.r = 16'(16'h2000 + i);
      settle();
      chk("t3_r_ready", 32'(mst_req.r_ready), 32'd1);
      chk("t3_r_valid", 32'(slv_resp.r_valid), 32'(i == 3));
      r_q.push_back(16'(16'h2000 + i));
      step();
    end
    mst_resp.r_valid = 1'b0;
    settle();
    chk("t3_full", 32'(mst_req.r_ready), 32'd0);
    chk("t3_r_valid_hold", 32'(slv_resp.r_valid), 32'd1);
    step();
    step();
    slv_req.r_ready = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("t3_r_burst", 32'(slv_resp.r_valid), 32'd1);
      chk("t3_r_ready_back", 32'(mst_req.r_ready), 32'(i != 0));
      step();
    end
    chk("t3_r_drained", 32'(slv_resp.r_valid), 32'd0);
    slv_req.r_ready = 1'b0;

    // B pair with delay 1.
    cfg_resp = 8'd1;
    slv_req.b_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mst_resp.b_valid = 1'b1;
      mst_resp.b = 8'(8'hB0 + i);
      b_q.push_back(8'(8'hB0 + i));
      step();
    end
    mst_resp.b_valid = 1'b0;
    step();
    step();
    settle();
    chk("t3b_b_drained", 32'(slv_resp.b_valid), 32'd0);
    slv_req.b_ready = 1'b0;

    // AR commit: raised delay must not retract a stalled head.
    cfg_req = 8'd1;
    mst_resp.ar_ready = 1'b0;
    slv_req.ar_valid = 1'b1;
    slv_req.ar = 16'h3A3A;
    ar_q.push_back(16'h3A3A);
    settle();
    chk("t4_ar_idle", 32'(mst_req.ar_valid), 32'd0);
    step();
    slv_req.ar = 16'h3B3B;
    ar_q.push_back(16'h3B3B);
    settle();
    chk("t4_ar_age0", 32'(mst_req.ar_valid), 32'd0);
    step();
    slv_req.ar_valid = 1'b0;
    settle();
    chk("t4_ar_valid", 32'(mst_req.ar_valid), 32'd1);
    chk("t4_ar_data", 32'(mst_req.ar), 32'h3A3A);
    step();
    cfg_req = 8'd200;
    settle();
    for (int j = 0; j < 5; j++) begin
      chk("t4_commit_valid", 32'(mst_req.ar_valid), 32'd1);
      chk("t4_commit_data", 32'(mst_req.ar), 32'h3A3A);
      step();
    end
    mst_resp.ar_ready = 1'b1;
    settle();
    chk("t4_pop_valid", 32'(mst_req.ar_valid), 32'd1);
    step();
    early = 0;
    for (int j = 0; j < 193; j++) begin
      if (mst_req.ar_valid) early++;
      step();
    end
    chk("t4_no_early", 32'(early), 32'd0);
    chk("t4_second_valid", 32'(mst_req.ar_valid), 32'd1);
    chk("t4_second_data", 32'(mst_req.ar), 32'h3B3B);
    step();
    chk("t4_ar_drained", 32'(mst_req.ar_valid), 32'd0);
    cfg_req = 8'd0;
    mst_resp.ar_ready = 1'b0;

    // Saturation on a 4-bit-age instance held for about 100 cycles.
    s_cfg_req = 4'd15;
    s_mst_resp.aw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_slv_req.aw_valid = 1'b1;
      s_slv_req.aw = 16'(16'h5000 + i);
      settle();
      chk("t5_ready", 32'(s_slv_resp.aw_ready), 32'd1);
      s_aw_q.push_back(16'(16'h5000 + i));
      step();
    end
    s_slv_req.aw_valid = 1'b0;
    early = 0;
    for (int j = 0; j < 13; j++) begin
      if (s_mst_req.aw_valid) early++;
      step();
    end
    chk("t5_no_early", 32'(early), 32'd0);
    chk("t5_first_valid", 32'(s_mst_req.aw_valid), 32'd1);
    early = 0;
    for (int j = 0; j < 85; j++) begin
      if (!s_mst_req.aw_valid) early++;
      step();
    end
    chk("t5_held", 32'(early), 32'd0);
    s_mst_resp.aw_ready = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("t5_release", 32'(s_mst_req.aw_valid), 32'd1);
      step();
    end
    chk("t5_drained", 32'(s_mst_req.aw_valid), 32'd0);
    s_mst_resp.aw_ready = 1'b0;

    // Reset with 3 AW and 2 B entries held: everything is discarded.
    cfg_req = 8'd50;
    cfg_resp = 8'd50;
    mst_resp.aw_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv_req.aw_valid = 1'b1;
      slv_req.aw = 16'(16'h6000 + i);
      mst_resp.b_valid = (i < 2);
      mst_resp.b = 8'(8'hC0 + i);
      step();
    end
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    settle();
    chk("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valids", 32'({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                              slv_resp.b_valid, slv_resp.r_valid}), 32'h0);
    chk("t6_rst_readies", 32'({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                               mst_req.b_ready, mst_req.r_ready}), 32'h1f);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    stale = 0;
    for (int j = 0; j < 60; j++) begin
      if (mst_req.aw_valid || slv_resp.b_valid || busy) stale++;
      step();
    end
    chk("t6_no_stale", 32'(stale), 32'd0);

    chk("sb_drained", 32'(aw_q.size() + w_q.size() + ar_q.size() + b_q.size()
                          + r_q.size() + s_aw_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_latency_injector.md
Name: axi_latency_injector

Overview:
- Per-channel pipelined AXI delay line between a slave port (upstream manager) and a master port (downstream subordinate).
- Each of the five channels (AW, W, AR, B, R) gets an independent timestamped FIFO. A beat is released only after it has aged a runtime-programmable number of cycles.
- Multiple beats per channel are in flight simultaneously; request and response delays are configured separately at runtime.
- Used in testbenches and SoC bring-up to model long-latency interconnect without throttling throughput.

Parameters:
aw_chan_t, logic, AW channel payload type
w_chan_t, logic, W channel payload type
b_chan_t, logic, B channel payload type
ar_chan_t, logic, AR channel payload type
r_chan_t, logic, R channel payload type
req_t, logic, AXI request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready)
resp_t, logic, AXI response struct (aw_ready, ar_ready, w_ready, b, b_valid, r, r_valid)
Depth, 4, entries per channel FIFO; must be >= 1
DelayWidth, 8, width of delay config and per-entry age counters; must be >= 1

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
cfg_req_delay_i  input  DelayWidth  extra delay in cycles for AW, W, AR
cfg_resp_delay_i  input  DelayWidth  extra delay in cycles for B, R
slv_req_i  input  req_t  slave-port request
slv_resp_o  output  resp_t  slave-port response
mst_req_o  output  req_t  master-port request
mst_resp_i  input  resp_t  master-port response
busy_o  output  1  high while any channel FIFO holds at least one entry

Behaviour:
- Reset: all FIFOs empty; all age counters 0; all commit flags 0.
  - Outputs in reset: all valid outputs 0; all ready outputs 1 (FIFOs not full); busy_o 0.
  - Payload outputs are don't-care while their valid is 0.
- Channel instance: one generic FIFO per channel.
  - Input side: valid_i/ready_o/payload_i. Output side: valid_o/ready_i/payload_o.
  - AW, W, AR use cfg_req_delay_i and run slave to master. B, R use cfg_resp_delay_i and run master to slave.
- Push:
  - ready_o = !full, registered state only; ready_o never depends on valid_i or ready_i.
  - On valid_i && ready_o the beat is written at the tail with age 0.
- Aging: every stored entry's age increments by 1 on each clock edge after capture, saturating at 2^DelayWidth-1. No wrap-around.
- Release:
  - valid_o = !empty && (head_age >= D || commit), where D is the live config value.
  - Minimum latency 1 cycle: with D=0, a beat accepted at edge t is valid in the cycle after t. General case: valid at t+1+D.
- Commit:
  - When valid_o is high and ready_i is low, a commit flag is set. valid_o and payload_o then hold stable until the handshake, even if D is raised meanwhile (AXI stability rule).
  - The flag clears on the pop.
- Pop: on valid_o && ready_i the head advances. The next head is evaluated in the following cycle with its own age, with no extra bubble when it is already eligible.
- Simultaneous push and pop:
  - Allowed when not full; occupancy is unchanged.
  - When full, a pop in a cycle does not enable a push in that same cycle; ready_o rises the next cycle.
- Throughput: sustained 1 beat/cycle per channel requires Depth >= D+2; otherwise throughput is bounded by Depth/(D+2).
- Ordering:
  - Strict FIFO order within each channel.
  - Channels are mutually independent: W may precede AW at the master port, and B/R timing is unrelated to request timing.
  - No AXI ID or burst semantics are interpreted; payloads pass through bit-exact.
- Config change mid-flight: affects only non-committed head eligibility; never reorders, drops or duplicates beats.
- busy_o = OR of !empty over all five channels, registered-state derived.
- Reset asserted mid-operation: all in-flight beats are discarded immediately and outputs return to reset values. Upstream must treat outstanding transactions as lost.

Test Plan:
- Reset, then single AW beat with cfg_req_delay_i=3, mst aw_ready=1, accepted at edge t -> mst_req_o.aw_valid first high in cycle t+4; payload bit-exact; slv aw_ready stays 1.
- cfg_req_delay_i=0, Depth=4, W burst of 16 back-to-back beats, mst w_ready=1 -> 16 beats out in order, first at t+1, one beat per cycle, no bubbles.
- cfg_resp_delay_i=2, slave r_ready=0 while 4 R beats are pushed -> slv r_valid rises at t+3; master r_ready drops after the 4th push (FIFO full); when slave r_ready=1 all 4 beats emerge on 4 consecutive cycles; master r_ready returns one cycle after the first pop.
- Commit: cfg_req_delay_i=1, AR head valid with mst ar_ready=0, then cfg raised to 200 -> ar_valid and payload stay stable until ar_ready=1; the next beat then waits the full 200 cycles.
- Saturation: DelayWidth=4, cfg=15, downstream stalled 100 cycles -> beats released in order on ready; no premature or lost releases from age wrap.
- Reset mid-burst with 3 AW and 2 B entries stored -> all valids 0 and busy_o 0 in the reset cycle; after release, no stale beats appear.
